// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD arbiter slice: FSM encoding and default datapath width.
package gcd_pkg;

    localparam int GCD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_step.sv
// One subtractive GCD iteration: subtract the smaller operand from the larger,
// or flag termination (equal operands or a zero operand) along with the result.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] next_a,
    output logic [W-1:0] next_b,
    output logic         done,
    output logic [W-1:0] done_val
);

    logic a_gt_b;

    assign a_gt_b   = (a > b);
    assign done     = (a == b) || (a == '0) || (b == '0);
    // Equal or b==0 both yield a; only a==0 yields b.
    assign done_val = (a == '0) ? b : a;
    assign next_a   = a_gt_b ? (a - b) : a;
    assign next_b   = a_gt_b ? b : (b - a);

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that time-shares one subtractive GCD datapath between NREQ
// requesters: grant, load operands, iterate one subtraction per clock, ack result.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int W    = GCD_W,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      result,
    output logic              result_valid,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);

    state_t         state, state_nxt;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   next_a, next_b, done_val;
    logic           done;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] pick, cand;
    logic           pick_vld;
    logic [W-1:0]   a_arr [NREQ];
    logic [W-1:0]   b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = a_in[i*W +: W];
        assign b_arr[i] = b_in[i*W +: W];
    end

    gcd_step #(.W(W)) u_step (
        .a        (a_q),
        .b        (b_q),
        .next_a   (next_a),
        .next_b   (next_b),
        .done     (done),
        .done_val (done_val)
    );

    // Scan from farthest to nearest so the requester closest after last_q wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        pick     = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDW'((int'(last_q) + off) % NREQ);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_vld) state_nxt = ST_RUN;
            ST_RUN:  if (done)     state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ack          = '0;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_RESP: begin
                busy          = 1'b1;
                result_valid  = 1'b1;
                ack[grant_id] = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; operands are sampled only on the IDLE grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            result   <= '0;
            grant_id <= '0;
            last_q   <= IDW'(NREQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        a_q      <= a_arr[pick];
                        b_q      <= b_arr[pick];
                        grant_id <= pick;
                    end
                end
                ST_RUN: begin
                    if (done) begin
                        result <= done_val;
                    end else begin
                        a_q <= next_a;
                        b_q <= next_b;
                    end
                end
                ST_RESP: last_q <= grant_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: hand-computed GCD results, latencies, grant order and reset behaviour.
module tb_gcd_arbiter;

    localparam int W    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      result;
    logic              result_valid;
    logic              busy;
    logic [IDW-1:0]    grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .a_in         (a_in),
        .b_in         (b_in),
        .ack          (ack),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    // Called from an IDLE cycle; counts cycles from the sampling edge to the ack.
    task automatic serve(input string tag, input int exp_id, input logic [W-1:0] exp_res, input int exp_lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack === '0 && n < 200);
        check({tag, ":latency"}, W'(n), W'(exp_lat));
        check({tag, ":ack"}, W'(ack), W'(1) << exp_id);
        check({tag, ":grant"}, W'(grant_id), W'(exp_id));
        check({tag, ":result"}, result, exp_res);
        check({tag, ":valid"}, W'(result_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea [5] = '{48, 30, 12, 12, 6};
        int eb [5] = '{18, 18, 18, 6, 6};
        int za [3] = '{0, 0, 35};
        int zb [3] = '{0, 35, 0};
        int zr [3] = '{0, 35, 35};
        int n;
        logic busy_ok;

        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset:ack", W'(ack), 0);
        check("reset:valid", W'(result_valid), 0);
        check("reset:result", result, 0);
        check("reset:busy", W'(busy), 0);
        check("reset:grant", W'(grant_id), 0);

        // gcd(48,18): four subtractions, ack six cycles after the sample.
        set_ops(0, 48, 18);
        req = 4'b0001;
        tick();
        check("single:grant", W'(grant_id), 0);
        check("single:busy", W'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("single:a%0d", i), dut.a_q, W'(ea[i]));
            check($sformatf("single:b%0d", i), dut.b_q, W'(eb[i]));
            tick();
        end
        check("single:ack", W'(ack), 1);
        check("single:result", result, 6);
        check("single:valid", W'(result_valid), 1);
        req = '0;
        tick();
        check("single:busy_after", W'(busy), 0);
        check("single:ack_after", W'(ack), 0);
        check("single:valid_after", W'(result_valid), 0);

        // Zero operands on requester 2, each terminating in one RUN cycle.
        for (int i = 0; i < 3; i++) begin
            set_ops(2, W'(za[i]), W'(zb[i]));
            req = 4'b0100;
            serve($sformatf("zero%0d", i), 2, W'(zr[i]), 2);
            req = '0;
            tick();
        end

        // last=2: requester 0 wins over 1 after wrapping; requester 3 never acked.
        set_ops(0, 12, 8);
        set_ops(1, 5, 0);
        req = 4'b0011;
        serve("wrap0", 0, 4, 4);
        req[0] = 1'b0;
        tick();
        serve("wrap1", 1, 5, 2);
        req = '0;
        tick();

        // Abort gcd(1000,1) in its tenth RUN cycle.
        set_ops(3, 1000, 1);
        req = 4'b1000;
        tick();
        check("abort:grant", W'(grant_id), 3);
        for (int c = 2; c <= 10; c++) tick();
        check("abort:busy_run10", W'(busy), 1);
        rst = 1'b1;
        tick();
        check("abort:ack", W'(ack), 0);
        check("abort:busy", W'(busy), 0);
        check("abort:valid", W'(result_valid), 0);
        check("abort:result", result, 0);
        check("abort:grant_reset", W'(grant_id), 0);
        rst = 1'b0;
        req = '0;
        tick();
        check("abort:no_late_ack", W'(ack), 0);
        check("abort:idle", W'(busy), 0);
        // Pointer back at NREQ-1, so requester 0 beats requester 3.
        set_ops(0, 9, 6);
        set_ops(3, 50, 20);
        req = 4'b1001;
        serve("post_rst", 0, 3, 4);
        req = '0;
        tick();

        // Consecutive Fibonacci F47/F46: coprime, 45 subtractions.
        set_ops(1, 32'd2971215073, 32'd1836311903);
        req     = 4'b0010;
        n       = 0;
        busy_ok = 1'b1;
        do begin
            tick();
            n++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end while (ack === '0 && n < 200);
        check("large:latency", W'(n), 47);
        check("large:result", result, 1);
        check("large:ack", W'(ack), 2);
        check("large:valid", W'(result_valid), 1);
        check("large:busy_throughout", W'(busy_ok), 1);
        req = '0;
        tick();
        check("large:valid_one_cycle", W'(result_valid), 0);
        check("large:ack_one_cycle", W'(ack), 0);

        // Fairness from a fresh reset with all requesters asserted.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 7, 7);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve($sformatf("rr%0d", k), k % NREQ, 7, 2);
            tick();
        end
        req = '0;
        tick();
        check("rr:idle_end", W'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
